clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Time-set sequencer for the clock chip: turns three debounced push-buttons into the
//  state[1:0] / num[5:0] / hour_enable / min_enable controls shared by the hour and
//  minute counters. Walks RUN -> SET_HOUR -> SET_MIN -> COMMIT -> RUN, preloads the
//  edit value from the live time, aborts on inactivity, and drives a display blink flag.
// PARAMETERS
//  TIMEOUT_S      30  sec_tick pulses without a button edge before a SET state aborts to RUN
//  COMMIT_CYCLES  2   clk cycles spent in COMMIT with the enables high (>=1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  sec_tick     in   1  1-cycle pulse once per second (clk domain)
//  btn_mode     in   1  debounced level, async to clk; rising edge = next field / confirm
//  btn_up       in   1  debounced level, async; rising edge = increment edited field
//  btn_down     in   1  debounced level, async; rising edge = decrement edited field
//  cur_hour     in   6  live hour count 0..23 (preload source)
//  cur_min      in   6  live minute count 0..59 (preload source)
//  state        out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 COMMIT
//  num          out  6  value being edited / value to commit
//  hour_enable  out  1  high in SET_HOUR and COMMIT
//  min_enable   out  1  high in SET_MIN and COMMIT
//  blink        out  1  edited-field blink flag for the display
// BEHAVIOUR
//  Reset: state=00, num=0, hour_enable=0, min_enable=0, blink=0, timeout count=0,
//   all sync/edge flops=0. Reset mid-edit discards the edit; no commit occurs.
//  Input path: per button 2-flop sync + previous-value flop; edge = sync2 & ~prev.
//   A level first sampled high at edge k acts at edge k+2 (outputs change after k+2).
//   Holding a button produces exactly one edge; no auto-repeat.
//  Priority within one cycle: mode > (up xor down). up and down together = no action.
//  Stored edit values: h_edit, m_edit. num = h_edit in SET_HOUR, m_edit in SET_MIN
//   and COMMIT, 0 in RUN.
//  RUN: mode edge -> SET_HOUR; h_edit<=cur_hour, m_edit<=cur_min; up/down ignored.
//  SET_HOUR: up: h_edit = (h_edit==23)?0:h_edit+1; down: (h_edit==0)?23:h_edit-1.
//   mode edge -> SET_MIN. hour_enable=1 so the hour counter captures num every cycle.
//  SET_MIN: same wrap rules over 0..59. mode edge -> COMMIT. min_enable=1.
//  COMMIT: held exactly COMMIT_CYCLES cycles, hour_enable=min_enable=1, then RUN.
//   Buttons are ignored in COMMIT.
//  Timeout: counter clears on any button edge and on entry to SET_HOUR; increments on
//   sec_tick in SET_HOUR/SET_MIN; on reaching TIMEOUT_S -> RUN directly with both
//   enables low (abort, live time unchanged). Button edge and final tick in the same
//   cycle: the button wins and the counter clears.
//  blink: 0 in RUN/COMMIT; set to 1 on entry to SET_HOUR; toggles on each sec_tick in
//   SET states; forced to 1 on an up/down edge.
//  All outputs registered; h_edit/m_edit are never outside 0..23 / 0..59.
// TESTING
//  1 Reset with cur_hour=9,cur_min=41; pulse mode -> 2 clks later state=01, num=9,
//    hour_enable=1, blink=1.
//  2 In SET_HOUR from 23, up x1 -> num=0; down x1 -> num=23. In SET_MIN from 0,
//    down -> num=59; up -> num=0.
//  3 Full sequence 9:41 -> up x3 (hour 12), mode, down x2 (min 39), mode -> state=11 for
//    2 clks with num=39 and both enables high, then state=00, enables 0.
//  4 Enter SET_MIN, no buttons, 30 sec_ticks -> state=00 after tick 30, no COMMIT seen,
//    enables 0; one up edge at tick 29 restarts the count.
//  5 up and down rise in the same cycle -> num unchanged; mode+up same cycle -> advance
//    to the next field, num not incremented.
//  6 Assert rst while in SET_MIN with m_edit=17 -> all outputs 0 immediately,
//    state=00, no enable pulse after release.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Control bundle between the time-set sequencer and its surroundings: buttons,
// second tick and live time in, edit state and counter load controls out.
interface clock_set_ctrl_if;
    logic       i_sec_tick;
    logic       i_btn_mode;
    logic       i_btn_up;
    logic       i_btn_down;
    logic [5:0] i_cur_hour;
    logic [5:0] i_cur_min;
    logic [1:0] o_state;
    logic [5:0] o_num;
    logic       o_hour_enable;
    logic       o_min_enable;
    logic       o_blink;

    modport master (
        output i_sec_tick, i_btn_mode, i_btn_up, i_btn_down, i_cur_hour, i_cur_min,
        input  o_state, o_num, o_hour_enable, o_min_enable, o_blink
    );

    modport slave (
        input  i_sec_tick, i_btn_mode, i_btn_up, i_btn_down, i_cur_hour, i_cur_min,
        output o_state, o_num, o_hour_enable, o_min_enable, o_blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: RUN -> SET_HOUR -> SET_MIN -> COMMIT -> RUN driven by three
// debounced buttons, with inactivity abort and a blink flag for the edited field.
module clock_set_ctrl #(
    parameter int TIMEOUT_S     = 30,
    parameter int COMMIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    clock_set_ctrl_if.slave bus
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;
    localparam logic [1:0] ST_COMMIT   = 2'b11;

    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam int CW = (COMMIT_CYCLES > 1) ? $clog2(COMMIT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);
    localparam logic [CW-1:0] CC_LAST = CW'(COMMIT_CYCLES - 1);

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_prev;
    logic [1:0]    r_state;
    logic [5:0]    r_hEdit;
    logic [5:0]    r_mEdit;
    logic [TW-1:0] r_toCnt;
    logic [CW-1:0] r_commitCnt;
    logic          r_blink;
    logic [5:0]    r_num;
    logic          r_hourEn;
    logic          r_minEn;

    logic [2:0]    w_edge;
    logic          w_modeEdge;
    logic          w_anyEdge;
    logic          w_step;
    logic          w_inc;
    logic [1:0]    w_nextState;
    logic [5:0]    w_nextH;
    logic [5:0]    w_nextM;
    logic [TW-1:0] w_nextTo;
    logic [CW-1:0] w_nextCc;
    logic          w_nextBlink;
    logic [5:0]    w_nextNum;
    logic          w_nextHourEn;
    logic          w_nextMinEn;

    // Button vector order is {mode, up, down}; mode outranks a lone up/down edge.
    assign w_edge     = r_sync2 & ~r_prev;
    assign w_modeEdge = w_edge[2];
    assign w_anyEdge  = |w_edge;
    assign w_step     = ~w_edge[2] & (w_edge[1] ^ w_edge[0]);
    assign w_inc      = w_edge[1];

    function automatic logic [5:0] stepWrap(input logic [5:0] v, input logic [5:0] maxV,
                                            input logic inc);
        if (inc)
            return (v >= maxV) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0 || v > maxV) ? maxV : v - 6'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {bus.i_btn_mode, bus.i_btn_up, bus.i_btn_down};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextH     = r_hEdit;
        w_nextM     = r_mEdit;
        w_nextTo    = r_toCnt;
        w_nextCc    = r_commitCnt;
        w_nextBlink = r_blink;
        case (r_state)
            ST_RUN: begin
                w_nextTo    = '0;
                w_nextCc    = '0;
                w_nextBlink = 1'b0;
                if (w_modeEdge) begin
                    w_nextState = ST_SET_HOUR;
                    w_nextH     = (bus.i_cur_hour > 6'd23) ? 6'd0 : bus.i_cur_hour;
                    w_nextM     = (bus.i_cur_min > 6'd59) ? 6'd0 : bus.i_cur_min;
                    w_nextBlink = 1'b1;
                end
            end
            ST_SET_HOUR, ST_SET_MIN: begin
                if (w_anyEdge)
                    w_nextTo = '0;
                else if (bus.i_sec_tick)
                    w_nextTo = r_toCnt + TW'(1);
                if (bus.i_sec_tick)
                    w_nextBlink = ~r_blink;
                if (w_modeEdge) begin
                    if (r_state == ST_SET_HOUR) begin
                        w_nextState = ST_SET_MIN;
                    end else begin
                        w_nextState = ST_COMMIT;
                        w_nextCc    = '0;
                        w_nextBlink = 1'b0;
                    end
                end else if (w_step) begin
                    w_nextBlink = 1'b1;
                    if (r_state == ST_SET_HOUR)
                        w_nextH = stepWrap(r_hEdit, 6'd23, w_inc);
                    else
                        w_nextM = stepWrap(r_mEdit, 6'd59, w_inc);
                end else if (!w_anyEdge && bus.i_sec_tick && r_toCnt == TO_LAST) begin
                    // Abort: leave the edit without ever raising both enables.
                    w_nextState = ST_RUN;
                    w_nextTo    = '0;
                    w_nextBlink = 1'b0;
                end
            end
            default: begin
                w_nextBlink = 1'b0;
                if (r_commitCnt == CC_LAST) begin
                    w_nextState = ST_RUN;
                    w_nextCc    = '0;
                end else begin
                    w_nextCc = r_commitCnt + CW'(1);
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_nextNum    = 6'd0;
        w_nextHourEn = 1'b0;
        w_nextMinEn  = 1'b0;
        case (w_nextState)
            ST_SET_HOUR: begin
                w_nextNum    = w_nextH;
                w_nextHourEn = 1'b1;
            end
            ST_SET_MIN: begin
                w_nextNum   = w_nextM;
                w_nextMinEn = 1'b1;
            end
            ST_COMMIT: begin
                w_nextNum    = w_nextM;
                w_nextHourEn = 1'b1;
                w_nextMinEn  = 1'b1;
            end
            default: begin
                w_nextNum = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_hEdit     <= '0;
            r_mEdit     <= '0;
            r_toCnt     <= '0;
            r_commitCnt <= '0;
            r_blink     <= 1'b0;
            r_num       <= '0;
            r_hourEn    <= 1'b0;
            r_minEn     <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_hEdit     <= w_nextH;
            r_mEdit     <= w_nextM;
            r_toCnt     <= w_nextTo;
            r_commitCnt <= w_nextCc;
            r_blink     <= w_nextBlink;
            r_num       <= w_nextNum;
            r_hourEn    <= w_nextHourEn;
            r_minEn     <= w_nextMinEn;
        end
    end

    assign bus.o_state       = r_state;
    assign bus.o_num         = r_num;
    assign bus.o_hour_enable = r_hourEn;
    assign bus.o_min_enable  = r_minEn;
    assign bus.o_blink       = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: table of button presses with expected outputs queued
// on a scoreboard, plus hand sequences for latency, commit, timeout and reset.
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_set_ctrl_if busIf ();

    clock_set_ctrl #(
        .TIMEOUT_S    (30),
        .COMMIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(busIf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  btn;
        logic [5:0]  curH;
        logic [5:0]  curM;
        logic [10:0] expOut;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] expOut;
    } exp_t;

    exp_t expQ[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    logic sawCommit;
    logic sawEnable;

    // Expected output word is {state, num, hour_enable, min_enable, blink}.
    function automatic logic [10:0] packOut(logic [1:0] st, int n, logic he, logic me, logic bl);
        return {st, 6'(n), he, me, bl};
    endfunction

    function automatic vec_t mkVec(string name, logic [2:0] btn, int h, int m, logic [10:0] e);
        vec_t v;
        v.name   = name;
        v.btn    = btn;
        v.curH   = 6'(h);
        v.curM   = 6'(m);
        v.expOut = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setButtons(logic [2:0] b);
        busIf.i_btn_mode = b[2];
        busIf.i_btn_up   = b[1];
        busIf.i_btn_down = b[0];
    endtask

    task automatic expectOut(string name, logic [10:0] e);
        exp_t x;
        x.name   = name;
        x.expOut = e;
        expQ.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t        x;
        logic [10:0] act;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        x   = expQ.pop_front();
        act = {busIf.o_state, busIf.o_num, busIf.o_hour_enable, busIf.o_min_enable, busIf.o_blink};
        if (act !== x.expOut) begin
            errors++;
            $display("[TB] FAIL %s: got state=%b num=%0d hen=%b men=%b blink=%b, expected state=%b num=%0d hen=%b men=%b blink=%b",
                     x.name, act[10:9], act[8:3], act[2], act[1], act[0],
                     x.expOut[10:9], x.expOut[8:3], x.expOut[2], x.expOut[1], x.expOut[0]);
        end
    endtask

    task automatic checkFlag(string name, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        busIf.i_cur_hour = v.curH;
        busIf.i_cur_min  = v.curM;
        expectOut(v.name, v.expOut);
        setButtons(v.btn);
        repeat (3) tick();
    endtask

    task automatic releaseButtons();
        setButtons(3'b000);
        repeat (3) tick();
    endtask

    task automatic press(logic [2:0] b);
        setButtons(b);
        repeat (3) tick();
        releaseButtons();
    endtask

    task automatic secPulse();
        busIf.i_sec_tick = 1'b1;
        tick();
        if (busIf.o_state == 2'b11) sawCommit = 1'b1;
        busIf.i_sec_tick = 1'b0;
        tick();
        if (busIf.o_state == 2'b11) sawCommit = 1'b1;
    endtask

    task automatic doReset(int h, int m);
        rst = 1'b1;
        setButtons(3'b000);
        busIf.i_sec_tick = 1'b0;
        busIf.i_cur_hour = 6'(h);
        busIf.i_cur_min  = 6'(m);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setButtons(3'b000);
        busIf.i_sec_tick = 1'b0;
        busIf.i_cur_hour = 6'd9;
        busIf.i_cur_min  = 6'd41;
        sawCommit = 1'b0;
        sawEnable = 1'b0;

        // Wrap, tie and priority rows with a 23:00 preload, then the 9:41 edit walk.
        tbl.push_back(mkVec("b_enter_hour", 3'b100, 23, 0, packOut(2'b01, 23, 1, 0, 1)));
        tbl.push_back(mkVec("b_up_wrap23",  3'b010, 23, 0, packOut(2'b01, 0, 1, 0, 1)));
        tbl.push_back(mkVec("b_down_wrap0", 3'b001, 23, 0, packOut(2'b01, 23, 1, 0, 1)));
        tbl.push_back(mkVec("b_up_and_down",3'b011, 23, 0, packOut(2'b01, 23, 1, 0, 1)));
        tbl.push_back(mkVec("b_enter_min",  3'b100, 23, 0, packOut(2'b10, 0, 0, 1, 1)));
        tbl.push_back(mkVec("b_down_wrap0m",3'b001, 23, 0, packOut(2'b10, 59, 0, 1, 1)));
        tbl.push_back(mkVec("b_up_wrap59",  3'b010, 23, 0, packOut(2'b10, 0, 0, 1, 1)));
        tbl.push_back(mkVec("b_up_min",     3'b010, 23, 0, packOut(2'b10, 1, 0, 1, 1)));
        tbl.push_back(mkVec("b_mode_up",    3'b110, 23, 0, packOut(2'b11, 1, 1, 1, 0)));
        tbl.push_back(mkVec("b_back_run",   3'b000, 23, 0, packOut(2'b00, 0, 0, 0, 0)));
        tbl.push_back(mkVec("a_enter_hour", 3'b100, 9, 41, packOut(2'b01, 9, 1, 0, 1)));
        tbl.push_back(mkVec("a_up1",        3'b010, 9, 41, packOut(2'b01, 10, 1, 0, 1)));
        tbl.push_back(mkVec("a_up2",        3'b010, 9, 41, packOut(2'b01, 11, 1, 0, 1)));
        tbl.push_back(mkVec("a_up3",        3'b010, 9, 41, packOut(2'b01, 12, 1, 0, 1)));
        tbl.push_back(mkVec("a_enter_min",  3'b100, 9, 41, packOut(2'b10, 41, 0, 1, 1)));
        tbl.push_back(mkVec("a_down1",      3'b001, 9, 41, packOut(2'b10, 40, 0, 1, 1)));
        tbl.push_back(mkVec("a_down2",      3'b001, 9, 41, packOut(2'b10, 39, 0, 1, 1)));

        // Reset values and the two-edge input latency.
        doReset(9, 41);
        expectOut("reset_state", packOut(2'b00, 0, 0, 0, 0));
        checkOutput();
        setButtons(3'b100);
        tick();
        tick();
        expectOut("mode_not_yet", packOut(2'b00, 0, 0, 0, 0));
        checkOutput();
        tick();
        expectOut("mode_latency", packOut(2'b01, 9, 1, 0, 1));
        checkOutput();
        releaseButtons();

        doReset(23, 0);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput();
            releaseButtons();
        end

        // COMMIT lasts exactly two cycles with the minute value on num.
        setButtons(3'b100);
        repeat (3) tick();
        expectOut("commit_cycle1", packOut(2'b11, 39, 1, 1, 0));
        checkOutput();
        tick();
        expectOut("commit_cycle2", packOut(2'b11, 39, 1, 1, 0));
        checkOutput();
        tick();
        expectOut("commit_to_run", packOut(2'b00, 0, 0, 0, 0));
        checkOutput();
        releaseButtons();

        // Inactivity abort after the 30th second tick.
        doReset(9, 41);
        press(3'b100);
        press(3'b100);
        sawCommit = 1'b0;
        for (int i = 0; i < 29; i++) secPulse();
        expectOut("timeout_tick29", packOut(2'b10, 41, 0, 1, 0));
        checkOutput();
        busIf.i_sec_tick = 1'b1;
        tick();
        if (busIf.o_state == 2'b11) sawCommit = 1'b1;
        busIf.i_sec_tick = 1'b0;
        expectOut("timeout_tick30", packOut(2'b00, 0, 0, 0, 0));
        checkOutput();
        tick();
        checkFlag("timeout_no_commit", sawCommit, 1'b0);

        // An up edge landing on tick 29 restarts the count.
        press(3'b100);
        press(3'b100);
        for (int i = 0; i < 28; i++) secPulse();
        setButtons(3'b010);
        tick();
        tick();
        busIf.i_sec_tick = 1'b1;
        tick();
        busIf.i_sec_tick = 1'b0;
        expectOut("restart_up_edge", packOut(2'b10, 42, 0, 1, 1));
        checkOutput();
        setButtons(3'b000);
        for (int i = 0; i < 29; i++) secPulse();
        expectOut("restart_still_set", packOut(2'b10, 42, 0, 1, 0));
        checkOutput();
        busIf.i_sec_tick = 1'b1;
        tick();
        busIf.i_sec_tick = 1'b0;
        expectOut("restart_abort", packOut(2'b00, 0, 0, 0, 0));
        checkOutput();
        tick();

        // Asynchronous reset in the middle of a minute edit.
        doReset(9, 17);
        press(3'b100);
        press(3'b100);
        expectOut("pre_reset_min17", packOut(2'b10, 17, 0, 1, 1));
        checkOutput();
        #2;
        rst = 1'b1;
        #1;
        expectOut("async_reset", packOut(2'b00, 0, 0, 0, 0));
        checkOutput();
        tick();
        tick();
        rst = 1'b0;
        sawEnable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busIf.o_hour_enable || busIf.o_min_enable || busIf.o_state != 2'b00)
                sawEnable = 1'b1;
        end
        checkFlag("no_enable_after_reset", sawEnable, 1'b0);
        checkFlag("scoreboard_drained", (expQ.size() == 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
